// File: rtl/sync_down_counter.sv
// sync_down_counter: falling-edge down counter with wrap/one-shot modes, load and cascade borrow
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_busy, r_done;
  // next count and state; load overrides everything, DONE is left only by load
  always_comb begin
    w_q_nxt     = r_q;
    w_state_nxt = r_state;
    if (load) begin
      w_q_nxt     = load_val;
      w_state_nxt = COUNT;
    end else begin
      case (r_state)
        IDLE: if (en && !mode) begin
          w_q_nxt     = '1;
          w_state_nxt = COUNT;
        end
        COUNT: if (en) begin
          if (r_q != '0) w_q_nxt = r_q - 1'b1;
          else if (!mode) w_q_nxt = '1;
          else w_state_nxt = DONE;
        end
        DONE: w_q_nxt = '0;
        default: begin
          w_q_nxt     = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end
  // state, count and decoded status flags all register on the falling edge
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= (w_state_nxt == COUNT);
      r_done  <= (w_state_nxt == DONE);
    end
  end
  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;
  assign tc   = (r_q == '0) && (r_state == COUNT) && en;
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: directed checks of the down counter at WIDTH 4 and 8
module tb_sync_down_counter;
  logic       clk = 1'b0;
  logic       reset, load, en, mode;
  logic [3:0] load_val, q;
  logic       tc, busy, done;
  logic       reset8, load8, en8, mode8;
  logic [7:0] load_val8, q8;
  logic       tc8, busy8, done8;
  int checks = 0;
  int errors = 0;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en), .mode(mode),
    .q(q), .tc(tc), .busy(busy), .done(done)
  );
  sync_down_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .load(load8), .load_val(load_val8), .en(en8), .mode(mode8),
    .q(q8), .tc(tc8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int eq, input bit etc, input bit eb, input bit ed);
    chk({tag, ".q"}, 16'(q), 16'(eq));
    chk({tag, ".tc"}, 16'(tc), 16'(etc));
    chk({tag, ".busy"}, 16'(busy), 16'(eb));
    chk({tag, ".done"}, 16'(done), 16'(ed));
  endtask

  initial begin
    int tc_cnt;
    reset = 0; load = 0; en = 0; mode = 0; load_val = 0;
    reset8 = 0; load8 = 0; en8 = 0; mode8 = 0; load_val8 = 0;
    #1 reset = 1; reset8 = 1;
    #1 chk4("reset", 0, 0, 0, 0);
    load = 1; load_val = 9; en = 1;
    tick; chk4("reset_hold", 0, 0, 0, 0);
    load = 0; mode = 1; reset = 0;
    tick; chk4("idle_oneshot_hold", 0, 0, 0, 0);
    mode = 0;
    tick; chk4("idle_start", 15, 0, 1, 0);
    tc_cnt = 0;
    for (int i = 14; i >= 0; i--) begin
      tick;
      chk("wrap.q", 16'(q), 16'(i));
      chk("wrap.busy", 16'(busy), 16'd1);
      if (tc) tc_cnt++;
    end
    chk("wrap.tc_at_zero", 16'(tc), 16'd1);
    tick; chk4("wrap_15", 15, 0, 1, 0);
    tick; chk4("wrap_14", 14, 0, 1, 0);
    chk("wrap.tc_cycles", 16'(tc_cnt), 16'd1);
    mode = 1; load = 1; load_val = 5; en = 0;
    tick; chk4("os_load", 5, 0, 1, 0);
    load = 0; en = 1;
    for (int i = 4; i >= 0; i--) begin
      tick;
      chk("os.q", 16'(q), 16'(i));
      chk("os.done", 16'(done), 16'd0);
    end
    chk("os.tc_zero", 16'(tc), 16'd1);
    tick; chk4("os_done", 0, 0, 0, 1);
    mode = 0;
    for (int i = 0; i < 10; i++) begin
      tick; chk4("done_hold", 0, 0, 0, 1);
    end
    load = 1; load_val = 7;
    tick; chk4("done_load", 7, 0, 1, 0);
    load_val = 3; en = 1;
    tick; chk4("prio_load", 3, 0, 1, 0);
    load_val = 6; en = 0;
    tick; chk4("hold_load", 6, 0, 1, 0);
    load = 0;
    for (int i = 0; i < 3; i++) begin
      tick; chk4("hold", 6, 0, 1, 0);
    end
    mode = 1; en = 1;
    tick; chk4("resume", 5, 0, 1, 0);
    mode = 0;
    for (int i = 4; i >= 0; i--) tick;
    chk4("mode_chg_zero", 0, 1, 1, 0);
    tick; chk4("mode_chg_wrap", 15, 0, 1, 0);
    load = 1; load_val = 0; mode = 1;
    tick; chk4("load0_os", 0, 1, 1, 0);
    load = 0;
    tick; chk4("load0_os_done", 0, 0, 0, 1);
    load = 1; mode = 0;
    tick; chk4("load0_wrap", 0, 1, 1, 0);
    load = 0;
    tick; chk4("load0_wrap_next", 15, 0, 1, 0);
    mode = 1; load = 1; load_val = 9;
    tick; chk4("ar_load", 9, 0, 1, 0);
    load = 0;
    tick; tick; tick;
    chk4("ar_at6", 6, 0, 1, 0);
    #2 reset = 1;
    #1 chk4("ar_async", 0, 0, 0, 0);
    reset = 0; mode = 0;
    tick; chk4("ar_restart", 15, 0, 1, 0);
    reset8 = 0; load8 = 1; load_val8 = 1;
    tick;
    chk("w8.load.q", 16'(q8), 16'd1);
    chk("w8.load.tc", 16'(tc8), 16'd0);
    load8 = 0; en8 = 1;
    tick;
    chk("w8.zero.q", 16'(q8), 16'd0);
    chk("w8.zero.tc", 16'(tc8), 16'd1);
    tick;
    chk("w8.wrap.q", 16'(q8), 16'd255);
    chk("w8.wrap.tc", 16'(tc8), 16'd0);
    tick;
    chk("w8.next.q", 16'(q8), 16'd254);
    chk("w8.next.tc", 16'(tc8), 16'd0);
    chk("w8.busy", 16'(busy8), 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
